// File: rtl/conversor_bcd_pkg.sv
// ============================================================================
//  Module   : conversor_bcd_pkg
//  Brief    : Shared constants and state encoding for the binary-to-BCD
//             converter (double-dabble, one bit per clock).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conversor_bcd_pkg;

   // Width of the binary value being converted
   localparam int LARGURA     = 32;
   // Digits presented at the outputs (units..thousands)
   localparam int NUM_DIGITOS = 4;
   // Accumulator depth: enough digits for any 32-bit unsigned value
   localparam int DIGITOS_ACC = 10;
   localparam int LARG_ACC    = 4 * DIGITOS_ACC;

   // Code the display decoders render as an empty digit
   localparam logic [3:0] BRANCO = 4'hE;

   typedef enum logic [0:0] {
      OCIOSO   = 1'b0,
      CONVERTE = 1'b1
   } estado_t;

endpackage

`default_nettype wire

// File: rtl/conversor_bcd_ajuste_bcd.sv
// ============================================================================
//  Module   : ajuste_bcd
//  Brief    : Double-dabble digit correction: add 3 when the digit is >= 5,
//             so the following left shift carries correctly into the next
//             decimal digit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ajuste_bcd
   import conversor_bcd_pkg::*;
(
   input  logic [3:0] entrada,
   output logic [3:0] saida
);

   assign saida = (entrada >= 4'd5) ? (entrada + 4'd3) : entrada;

endmodule

`default_nettype wire

// File: rtl/conversor_bcd.sv
// ============================================================================
//  Module   : conversor_bcd
//  Brief    : Sequential binary-to-BCD converter. One double-dabble
//             iteration per clock; the four low digits and an overflow flag
//             are registered when the last iteration completes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conversor_bcd
   import conversor_bcd_pkg::*;
#(
   parameter int LARGURA     = conversor_bcd_pkg::LARGURA,
   parameter int NUM_DIGITOS = conversor_bcd_pkg::NUM_DIGITOS
)(
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] valor,
   input  logic               controle,
   output logic [3:0]         digito0,
   output logic [3:0]         digito1,
   output logic [3:0]         digito2,
   output logic [3:0]         digito3,
   output logic               ocupado,
   output logic               pronto,
   output logic               estouro
);

   localparam logic [5:0] ULTIMA_ITER = 6'(LARGURA - 1);

   estado_t               estado;
   estado_t               prox_estado;
   logic [5:0]            contador;
   logic [LARGURA-1:0]    desloc;
   logic [LARG_ACC-1:0]   acc;
   logic [LARG_ACC-1:0]   acc_ajustado;
   logic [LARG_ACC-1:0]   acc_prox;
   logic [LARGURA-1:0]    desloc_prox;
   logic                  captura;
   logic                  ultima;
   logic                  excede;

   // One correction cell per accumulator digit
   generate
      for (genvar i = 0; i < DIGITOS_ACC; i++) begin : g_ajuste
         ajuste_bcd u_ajuste (
            .entrada (acc[4*i +: 4]),
            .saida   (acc_ajustado[4*i +: 4])
         );
      end
   endgenerate

   // Shift {corrected accumulator, shift register} left by one
   assign acc_prox    = {acc_ajustado[LARG_ACC-2:0], desloc[LARGURA-1]};
   assign desloc_prox = {desloc[LARGURA-2:0], 1'b0};

   // Anything above the displayed digits (including a carry out of the top
   // digit) means the value does not fit on the display
   assign excede  = (|acc_prox[LARG_ACC-1:4*NUM_DIGITOS]) | acc_ajustado[LARG_ACC-1];

   assign ocupado = (estado == CONVERTE);

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= OCIOSO;
      end else begin
         estado <= prox_estado;
      end
   end

   // Next-state logic: start on controle in idle, leave after the last bit
   always_comb begin
      prox_estado = estado;
      captura     = 1'b0;
      ultima      = 1'b0;
      case (estado)
         OCIOSO: begin
            if (controle) begin
               captura     = 1'b1;
               prox_estado = CONVERTE;
            end
         end
         CONVERTE: begin
            if (contador == ULTIMA_ITER) begin
               ultima      = 1'b1;
               prox_estado = OCIOSO;
            end
         end
         default: prox_estado = OCIOSO;
      endcase
   end

   // Datapath: capture, iterate, and publish the final digits
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         contador <= 6'd0;
         desloc   <= '0;
         acc      <= '0;
         digito0  <= BRANCO;
         digito1  <= BRANCO;
         digito2  <= BRANCO;
         digito3  <= BRANCO;
         pronto   <= 1'b0;
         estouro  <= 1'b0;
      end else begin
         pronto <= 1'b0;
         if (captura) begin
            desloc   <= valor;
            acc      <= '0;
            contador <= 6'd0;
         end else if (estado == CONVERTE) begin
            acc      <= acc_prox;
            desloc   <= desloc_prox;
            contador <= contador + 6'd1;
            if (ultima) begin
               digito0 <= acc_prox[3:0];
               digito1 <= acc_prox[7:4];
               digito2 <= acc_prox[11:8];
               digito3 <= acc_prox[15:12];
               estouro <= excede;
               pronto  <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_conversor_bcd.sv
// ============================================================================
//  Module   : tb_conversor_bcd
//  Brief    : Self-checking bench for conversor_bcd with a decimal reference
//             model built from plain division/modulo arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conversor_bcd;

   logic        clock = 1'b0;
   logic        reset;
   logic        controle;
   logic [31:0] valor;
   logic [3:0]  digito0, digito1, digito2, digito3;
   logic        ocupado, pronto, estouro;

   int n_aval  = 0;
   int n_falhas = 0;

   conversor_bcd dut (
      .clock    (clock),
      .reset    (reset),
      .valor    (valor),
      .controle (controle),
      .digito0  (digito0),
      .digito1  (digito1),
      .digito2  (digito2),
      .digito3  (digito3),
      .ocupado  (ocupado),
      .pronto   (pronto),
      .estouro  (estouro)
   );

   always #5 clock = ~clock;

   // Reference: the four displayed digits of v (v mod 10000), thousands first
   function automatic logic [15:0] ref_digitos(input longint unsigned v);
      longint unsigned r;
      r = v % 64'd10000;
      return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
   endfunction

   function automatic logic ref_estouro(input longint unsigned v);
      return (v > 64'd9999);
   endfunction

   // Start one conversion with a single-cycle controle pulse, scramble valor
   // afterwards, and wait (bounded) for pronto. lat = -1 on timeout.
   task automatic run_conv(input logic [31:0] v, output int lat);
      @(negedge clock);
      valor    = v;
      controle = 1'b1;
      @(negedge clock);
      controle = 1'b0;
      valor    = $urandom;
      lat      = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (pronto) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset    = 1'b0;
      controle = 1'b1;
      valor    = 32'd1234;
      repeat (3) @(negedge clock);
      n_aval++;
      if ({digito3, digito2, digito1, digito0} !== 16'hEEEE) begin
         n_falhas++;
         $display("FAIL reset_digits: got %h expected eeee", {digito3, digito2, digito1, digito0});
      end
      n_aval++;
      if ({ocupado, pronto, estouro} !== 3'b000) begin
         n_falhas++;
         $display("FAIL reset_flags: got %b expected 000", {ocupado, pronto, estouro});
      end
      controle = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_aval++;
      if (ocupado !== 1'b0) begin
         n_falhas++;
         $display("FAIL reset_no_start: ocupado got %b expected 0", ocupado);
      end
   endtask

   task automatic test_zero;
      int lat;
      run_conv(32'd0, lat);
      n_aval++;
      if (lat !== 32) begin
         n_falhas++;
         $display("FAIL zero_latency: got %0d expected 32", lat);
      end
      n_aval++;
      if ({estouro, digito3, digito2, digito1, digito0} !== 17'h0) begin
         n_falhas++;
         $display("FAIL zero_result: got %h expected 0", {estouro, digito3, digito2, digito1, digito0});
      end
      n_aval++;
      if (ocupado !== 1'b0) begin
         n_falhas++;
         $display("FAIL zero_ocupado_at_pronto: got %b expected 0", ocupado);
      end
      @(negedge clock);
      n_aval++;
      if ({pronto, digito3, digito2, digito1, digito0} !== 17'h0) begin
         n_falhas++;
         $display("FAIL zero_hold: got %h expected 0", {pronto, digito3, digito2, digito1, digito0});
      end
   endtask

   task automatic test_known;
      logic [31:0] casos [7];
      int lat;
      casos = '{32'd1234, 32'd9999, 32'd10000, 32'hFFFF_FFFF, 32'd9, 32'd10, 32'd99999};
      foreach (casos[i]) begin
         run_conv(casos[i], lat);
         n_aval++;
         if (lat !== 32) begin
            n_falhas++;
            $display("FAIL known_latency[%0d]: got %0d expected 32", casos[i], lat);
         end
         n_aval++;
         if ({estouro, digito3, digito2, digito1, digito0} !==
             {ref_estouro(longint'(casos[i])), ref_digitos(longint'(casos[i]))}) begin
            n_falhas++;
            $display("FAIL known_result[%0d]: got %h expected %h", casos[i],
                     {estouro, digito3, digito2, digito1, digito0},
                     {ref_estouro(longint'(casos[i])), ref_digitos(longint'(casos[i]))});
         end
      end
   endtask

   task automatic test_ignore_controle;
      int          pulsos;
      logic [15:0] visto;
      pulsos = 0;
      visto  = 16'h0;
      @(negedge clock);
      valor    = 32'd1234;
      controle = 1'b1;
      @(negedge clock);
      controle = 1'b0;
      repeat (9) @(negedge clock);
      valor    = 32'd5678;
      controle = 1'b1;
      @(negedge clock);
      controle = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         if (pronto) begin
            pulsos++;
            visto = {digito3, digito2, digito1, digito0};
         end
      end
      n_aval++;
      if (pulsos !== 1) begin
         n_falhas++;
         $display("FAIL ignore_pulses: got %0d expected 1", pulsos);
      end
      n_aval++;
      if (visto !== 16'h1234) begin
         n_falhas++;
         $display("FAIL ignore_result: got %h expected 1234", visto);
      end
      n_aval++;
      if (ocupado !== 1'b0) begin
         n_falhas++;
         $display("FAIL ignore_restart: ocupado got %b expected 0", ocupado);
      end
   endtask

   task automatic test_reset_mid;
      int   lat;
      logic visto_pronto;
      visto_pronto = 1'b0;
      @(negedge clock);
      valor    = 32'd87654321;
      controle = 1'b1;
      @(negedge clock);
      controle = 1'b0;
      repeat (15) @(negedge clock);
      reset = 1'b0;
      #1;
      n_aval++;
      if ({digito3, digito2, digito1, digito0, ocupado, pronto, estouro} !== {16'hEEEE, 3'b000}) begin
         n_falhas++;
         $display("FAIL midreset_state: got %h/%b expected eeee/000",
                  {digito3, digito2, digito1, digito0}, {ocupado, pronto, estouro});
      end
      repeat (3) begin
         @(negedge clock);
         if (pronto) visto_pronto = 1'b1;
      end
      reset = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (pronto || ocupado) visto_pronto = 1'b1;
      end
      n_aval++;
      if (visto_pronto !== 1'b0) begin
         n_falhas++;
         $display("FAIL midreset_no_pronto: activity got %b expected 0", visto_pronto);
      end
      run_conv(32'd42, lat);
      n_aval++;
      if ((lat !== 32) || ({estouro, digito3, digito2, digito1, digito0} !== 17'h00042)) begin
         n_falhas++;
         $display("FAIL midreset_restart: lat %0d result %h expected lat 32 result 00042",
                  lat, {estouro, digito3, digito2, digito1, digito0});
      end
   endtask

   task automatic test_back_to_back;
      int   tempos[$];
      logic pronto_ant;
      logic primeiro;
      pronto_ant = 1'b0;
      primeiro   = 1'b0;
      @(negedge clock);
      valor    = 32'd7;
      controle = 1'b1;
      for (int k = 0; k < 150; k++) begin
         @(negedge clock);
         if (pronto) begin
            tempos.push_back(k);
            primeiro = 1'b1;
         end
         n_aval++;
         if (pronto && pronto_ant) begin
            n_falhas++;
            $display("FAIL b2b_double_pronto: at cycle %0d pronto high twice, expected single pulse", k);
         end
         if (primeiro) begin
            n_aval++;
            if ({estouro, digito3, digito2, digito1, digito0} !== 17'h00007) begin
               n_falhas++;
               $display("FAIL b2b_stable[%0d]: got %h expected 00007", k,
                        {estouro, digito3, digito2, digito1, digito0});
            end
         end
         pronto_ant = pronto;
      end
      controle = 1'b0;
      n_aval++;
      if (tempos.size() < 4) begin
         n_falhas++;
         $display("FAIL b2b_count: got %0d pulses expected at least 4", tempos.size());
      end
      for (int i = 1; i < tempos.size(); i++) begin
         n_aval++;
         if (tempos[i] - tempos[i-1] !== 33) begin
            n_falhas++;
            $display("FAIL b2b_period: got %0d expected 33", tempos[i] - tempos[i-1]);
         end
      end
      repeat (40) @(negedge clock);
   endtask

   task automatic test_random;
      logic [31:0] v;
      int          lat;
      for (int i = 0; i < 25; i++) begin
         v = (i % 2 == 0) ? 32'($urandom_range(0, 12000)) : $urandom;
         run_conv(v, lat);
         n_aval++;
         if ((lat !== 32) ||
             ({estouro, digito3, digito2, digito1, digito0} !==
              {ref_estouro(longint'(v)), ref_digitos(longint'(v))})) begin
            n_falhas++;
            $display("FAIL random[%0d]: lat %0d result %h expected lat 32 result %h", v, lat,
                     {estouro, digito3, digito2, digito1, digito0},
                     {ref_estouro(longint'(v)), ref_digitos(longint'(v))});
         end
      end
   endtask

   // Absolute time bound so the run can never hang
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      controle = 1'b0;
      valor    = 32'd0;
      reset    = 1'b0;
      test_reset();
      test_zero();
      test_known();
      test_ignore_controle();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
      $finish;
   end

endmodule

`default_nettype wire
